// File: rtl/pc_unit_if.sv
// Request/response bundle between the pipeline control (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              pc_write_i;
  logic              exc_i;
  logic [ADDR_W-1:0] epc_i;
  logic              br_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              jmp_i;
  logic [ADDR_W-1:0] jmp_target_i;
  logic [ADDR_W-1:0] pc_out_o;
  logic [ADDR_W-1:0] pc_plus_o;
  logic              fetch_valid_o;
  logic              redirect_o;
  logic              pend_o;
  logic [ADDR_W-1:0] epc_o;

  modport master (
    output pc_write_i, exc_i, epc_i, br_i, br_target_i, jmp_i, jmp_target_i,
    input  pc_out_o, pc_plus_o, fetch_valid_o, redirect_o, pend_o, epc_o
  );

  modport slave (
    input  pc_write_i, exc_i, epc_i, br_i, br_target_i, jmp_i, jmp_target_i,
    output pc_out_o, pc_plus_o, fetch_valid_o, redirect_o, pend_o, epc_o
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with fixed-priority redirect arbitration and stall-safe
// redirect latching.
//   state | meaning
//   RUN   | no redirect waiting; PC steps or redirects when pc_write_i = 1
//   HELD  | a redirect is latched, waiting for the stall to lift
module pc_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [31:0]       EXC_VEC   = 32'h0000_0080,
  parameter int unsigned       STEP      = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  pc_unit_if.slave   bus
);
  localparam logic [ADDR_W-1:0] EXC_TGT = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);

  typedef enum logic {RUN, HELD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        pend_prio_q, pend_prio_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              redir_q, redir_d;
  logic              out_of_rst_q;
  logic [ADDR_W-1:0] epc_q;

  logic              new_req;
  logic [1:0]        new_prio;
  logic [ADDR_W-1:0] new_tgt;
  logic              take_new;

  always_comb begin
    new_req  = bus.exc_i | bus.br_i | bus.jmp_i;
    new_prio = 2'd2;
    new_tgt  = bus.jmp_target_i;
    if (bus.exc_i) begin
      new_prio = 2'd0;
      new_tgt  = EXC_TGT;
    end else if (bus.br_i) begin
      new_prio = 2'd1;
      new_tgt  = bus.br_target_i;
    end
    // Newer request wins ties against the latched one.
    take_new = new_req && (new_prio <= pend_prio_q);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_prio_d = pend_prio_q;
    pend_tgt_d  = pend_tgt_q;
    redir_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.pc_write_i) begin
          if (new_req) begin
            pc_d    = new_tgt;
            redir_d = 1'b1;
          end else begin
            pc_d = pc_q + STEP_W;
          end
        end else if (new_req) begin
          pend_prio_d = new_prio;
          pend_tgt_d  = new_tgt;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (take_new) begin
          pend_prio_d = new_prio;
          pend_tgt_d  = new_tgt;
        end
        if (bus.pc_write_i) begin
          pc_d    = take_new ? new_tgt : pend_tgt_q;
          redir_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_VEC;
      pend_prio_q  <= 2'd0;
      pend_tgt_q   <= '0;
      redir_q      <= 1'b0;
      out_of_rst_q <= 1'b0;
      epc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_prio_q  <= pend_prio_d;
      pend_tgt_q   <= pend_tgt_d;
      redir_q      <= redir_d;
      out_of_rst_q <= 1'b1;
      if (bus.exc_i) epc_q <= bus.epc_i;
    end
  end

  assign bus.pc_out_o      = pc_q;
  assign bus.pc_plus_o     = pc_q + STEP_W;
  assign bus.redirect_o    = redir_q;
  assign bus.pend_o        = (state_q == HELD);
  assign bus.epc_o         = epc_q;
  assign bus.fetch_valid_o = out_of_rst_q && (state_q == RUN) && !redir_q;
endmodule

// File: tb/tb_pc_unit.sv
// Randomized and directed checks of pc_unit against a behavioural model.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(32)) bus ();
  pc_unit_if #(.ADDR_W(8))  bus8 ();

  pc_unit #(.ADDR_W(32), .RESET_VEC(32'h100)) dut (
    .clk_i(clk), .rst_n(rst_n), .bus(bus)
  );
  pc_unit #(.ADDR_W(8), .RESET_VEC(8'hF8)) dut8 (
    .clk_i(clk), .rst_n(rst_n), .bus(bus8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0] m_pc, m_ptgt, m_epc;
  int          m_pprio;
  bit          m_pend, m_redir, m_oor;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit pw, input bit exc, input logic [31:0] epc,
                       input bit br, input logic [31:0] brt,
                       input bit jmp, input logic [31:0] jmpt);
    bus.pc_write_i   = pw;
    bus.exc_i        = exc;
    bus.epc_i        = epc;
    bus.br_i         = br;
    bus.br_target_i  = brt;
    bus.jmp_i        = jmp;
    bus.jmp_target_i = jmpt;
  endtask

  task automatic model_reset();
    m_pc = 32'h100; m_ptgt = 0; m_epc = 0; m_pprio = 3;
    m_pend = 0; m_redir = 0; m_oor = 0;
  endtask

  // Applies the architectural rules for one rising edge using the current inputs.
  task automatic model_edge();
    bit          req;
    int          prio;
    logic [31:0] tgt;
    req = 0; prio = 3; tgt = 0;
    if (bus.jmp_i) begin req = 1; prio = 2; tgt = bus.jmp_target_i; end
    if (bus.br_i)  begin req = 1; prio = 1; tgt = bus.br_target_i; end
    if (bus.exc_i) begin req = 1; prio = 0; tgt = 32'h80; m_epc = bus.epc_i; end
    m_redir = 0;
    if (m_pend) begin
      if (req && prio <= m_pprio) begin m_pprio = prio; m_ptgt = tgt; end
      if (bus.pc_write_i) begin m_pc = m_ptgt; m_redir = 1; m_pend = 0; end
    end else if (bus.pc_write_i) begin
      if (req) begin m_pc = tgt; m_redir = 1; end
      else m_pc = m_pc + 32'd4;
    end else if (req) begin
      m_pend = 1; m_pprio = prio; m_ptgt = tgt;
    end
    m_oor = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    bus.pc_out_o, m_pc);
    chk({tag, ".plus"},  bus.pc_plus_o, m_pc + 32'd4);
    chk({tag, ".redir"}, 32'(bus.redirect_o), 32'(m_redir));
    chk({tag, ".pend"},  32'(bus.pend_o), 32'(m_pend));
    chk({tag, ".valid"}, 32'(bus.fetch_valid_o), 32'(m_oor && !m_pend && !m_redir));
    chk({tag, ".epc"},   bus.epc_o, m_epc);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    bus8.pc_write_i = 1'b1; bus8.exc_i = 1'b0; bus8.epc_i = '0;
    bus8.br_i = 1'b0; bus8.br_target_i = '0; bus8.jmp_i = 1'b0; bus8.jmp_target_i = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("rst_pc_const", bus.pc_out_o, 32'h100);
    chk("rst_valid_const", 32'(bus.fetch_valid_o), 32'd0);
    rst_n = 1'b1;

    // Sequential fetch and 8-bit wrap
    step("seq1");
    chk("seq1_pc", bus.pc_out_o, 32'h104);
    chk("seq1_valid", 32'(bus.fetch_valid_o), 32'd1);
    chk("w8_pc1", 32'(bus8.pc_out_o), 32'hFC);
    chk("w8_plus1", 32'(bus8.pc_plus_o), 32'h00);
    step("seq2");
    chk("w8_pc2", 32'(bus8.pc_out_o), 32'h00);
    chk("w8_plus2", 32'(bus8.pc_plus_o), 32'h04);
    step("seq3");
    chk("seq3_pc", bus.pc_out_o, 32'h10C);

    // Branch beats jump
    drive(1, 0, 0, 1, 32'h200, 1, 32'h300);
    step("brjmp");
    chk("brjmp_pc", bus.pc_out_o, 32'h200);
    chk("brjmp_redir", 32'(bus.redirect_o), 32'd1);
    chk("brjmp_valid", 32'(bus.fetch_valid_o), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step("brjmp_after");
    chk("brjmp_pulse_end", 32'(bus.redirect_o), 32'd0);

    // Stalled jump then stalled branch
    drive(0, 0, 0, 0, 0, 1, 32'h300);
    step("st1");
    drive(0, 0, 0, 1, 32'h200, 0, 0);
    step("st2");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("st3");
    chk("st3_pend", 32'(bus.pend_o), 32'd1);
    chk("st3_hold", bus.pc_out_o, 32'h204);
    drive(1, 0, 0, 0, 0, 0, 0);
    step("st_rel");
    chk("st_rel_pc", bus.pc_out_o, 32'h200);
    step("st_rel2");
    chk("st_rel2_pc", bus.pc_out_o, 32'h204);

    // Stalled exception beats a later stalled jump
    drive(0, 1, 32'h44, 0, 0, 0, 0);
    step("ex1");
    drive(0, 0, 0, 0, 0, 1, 32'h300);
    step("ex2");
    drive(1, 0, 0, 0, 0, 0, 0);
    step("ex_rel");
    chk("ex_rel_pc", bus.pc_out_o, 32'h80);
    chk("ex_epc", bus.epc_o, 32'h44);

    // Reset while HELD
    drive(0, 0, 0, 1, 32'h500, 0, 0);
    step("rh1");
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rh_rst");
    chk("rh_pend", 32'(bus.pend_o), 32'd0);
    chk("rh_pc", bus.pc_out_o, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("rh_after");
    chk("rh_seq_pc", bus.pc_out_o, 32'h10C);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0,
            $urandom_range(9, 0) == 0, $urandom,
            $urandom_range(4, 0) == 0, $urandom,
            $urandom_range(4, 0) == 0, $urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
